// File: rtl/serial_digit_sub_pkg.sv
// Shared types and default sizing for the digit-serial subtractor.
package serial_digit_sub_pkg;

  localparam int DefaultWidth = 8;
  localparam int DefaultDigit = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } subStateT;

endpackage

// File: rtl/full_sub_digit.sv
// Combinational DIGIT-bit ripple full subtractor: d = a - b - bin, bout = borrow out of the MSB.
module full_sub_digit #(
  parameter int DIGIT = serial_digit_sub_pkg::DefaultDigit
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  always_comb begin
    logic borrow;
    // NOTE: every output gets a value before the loop so no path leaves it unassigned (no latch).
    d      = '0;
    borrow = bin;
    for (int i = 0; i < DIGIT; i++) begin
      d[i]   = a[i] ^ b[i] ^ borrow;
      borrow = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow);
    end
    bout = borrow;
  end

endmodule

// File: rtl/serial_digit_sub.sv
// Digit-serial subtractor: DIGIT bits per cycle, valid/ready on both sides.
// Optional macro SERIAL_DIGIT_SUB_SAT_EN clamps Diff to zero when the final borrow is set.
module serial_digit_sub
  import serial_digit_sub_pkg::*;
#(
  parameter int WIDTH = DefaultWidth,
  parameter int DIGIT = DefaultDigit
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BorrowIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             BorrowOut,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gBadParams
    $error("serial_digit_sub: WIDTH must be a positive multiple of DIGIT");
  end

  subStateT               state;
  logic [WIDTH-1:0]       aShift;
  logic [WIDTH-1:0]       bShift;
  logic [WIDTH-1:0]       diffShift;
  logic                   borrowReg;
  logic [CW-1:0]          count;
  logic [DIGIT-1:0]       digitDiff;
  logic                   digitBorrow;
  logic [WIDTH+DIGIT-1:0] shiftCat;
  logic [WIDTH-1:0]       nextDiff;
  logic [WIDTH-1:0]       finalDiff;

  full_sub_digit #(.DIGIT(DIGIT)) uDigit (
    .a    (aShift[DIGIT-1:0]),
    .b    (bShift[DIGIT-1:0]),
    .bin  (borrowReg),
    .d    (digitDiff),
    .bout (digitBorrow)
  );

  // New digit enters at the MSB end; the concatenation also covers DIGIT == WIDTH.
  assign shiftCat = {digitDiff, diffShift};
  assign nextDiff = shiftCat[WIDTH+DIGIT-1:DIGIT];

`ifdef SERIAL_DIGIT_SUB_SAT_EN
  assign finalDiff = digitBorrow ? '0 : nextDiff;
`else
  assign finalDiff = nextDiff;
`endif

  // Diff/BorrowOut are separate from the working shift/borrow registers so they
  // hold the previous result while a new operation is in flight.
  // NOTE: all state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      aShift    <= '0;
      bShift    <= '0;
      diffShift <= '0;
      borrowReg <= 1'b0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      Diff      <= '0;
      BorrowOut <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            aShift    <= A;
            bShift    <= B;
            borrowReg <= BorrowIn;
            diffShift <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          aShift    <= aShift >> DIGIT;
          bShift    <= bShift >> DIGIT;
          diffShift <= nextDiff;
          borrowReg <= digitBorrow;
          count     <= count + CW'(1);
          if (count == CW'(N - 1)) begin
            Diff      <= finalDiff;
            BorrowOut <= digitBorrow;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_digit_sub.sv
// Self-checking bench: WIDTH=8/DIGIT=2 directed and random ops, plus exhaustive WIDTH=2 with DIGIT=1 and DIGIT=2.
module tb_serial_digit_sub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-bit, 2-bit digit instance
  logic       inValid, outReady, bIn;
  logic [7:0] a, b;
  logic       inReady, outValid, bOut, busy;
  logic [7:0] diff;

  // Shared stimulus for the two 2-bit instances
  logic       inValid2, outReady2, bIn2;
  logic [1:0] a2, b2;
  logic       inReady21, outValid21, bOut21, busy21;
  logic [1:0] diff21;
  logic       inReady22, outValid22, bOut22, busy22;
  logic [1:0] diff22;

  int errors = 0;
  int checks = 0;

  serial_digit_sub #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .A(a), .B(b), .BorrowIn(bIn), .out_valid(outValid), .out_ready(outReady),
    .Diff(diff), .BorrowOut(bOut), .busy(busy)
  );

  serial_digit_sub #(.WIDTH(2), .DIGIT(1)) dut21 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid2), .in_ready(inReady21),
    .A(a2), .B(b2), .BorrowIn(bIn2), .out_valid(outValid21), .out_ready(outReady2),
    .Diff(diff21), .BorrowOut(bOut21), .busy(busy21)
  );

  serial_digit_sub #(.WIDTH(2), .DIGIT(2)) dut22 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid2), .in_ready(inReady22),
    .A(a2), .B(b2), .BorrowIn(bIn2), .out_valid(outValid22), .out_ready(outReady2),
    .Diff(diff22), .BorrowOut(bOut22), .busy(busy22)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands; returns {borrow, diff}.
  function automatic logic [8:0] refSub(input int w, input int av, input int bv, input int bi);
    int d;
    logic borrow;
    logic [7:0] res;
    d      = av - bv - bi;
    borrow = (av < bv + bi);
    res    = 8'((d + (1 << (w + 1))) & ((1 << w) - 1));
`ifdef SERIAL_DIGIT_SUB_SAT_EN
    if (borrow) res = '0;
`endif
    return {borrow, res};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runOp8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        input int holdCycles, input bit pulseInRun);
    logic [8:0] exp;
    int lat;
    exp = refSub(8, int'(av), int'(bv), int'(bi));
    check("in_ready_idle", inReady, 1);
    a = av; b = bv; bIn = bi; inValid = 1'b1; outReady = 1'b0;
    tick();
    inValid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bIn = 1'($urandom);
    check("busy_run", busy, 1);
    check("in_ready_run", inReady, 0);
    lat = 0;
    while (!outValid && lat < 20) begin
      if (pulseInRun) inValid = 1'($urandom);
      tick();
      lat++;
    end
    inValid = 1'b0;
    check("latency", lat, 4);
    check("diff", diff, exp[7:0]);
    check("borrow_out", bOut, exp[8]);
    check("in_ready_done", inReady, 0);
    for (int i = 0; i < holdCycles; i++) begin
      inValid = 1'($urandom);
      tick();
      check("hold_out_valid", outValid, 1);
      check("hold_diff", diff, exp[7:0]);
      check("hold_in_ready", inReady, 0);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    check("post_out_valid", outValid, 0);
    check("post_in_ready", inReady, 1);
    check("post_busy", busy, 0);
    check("post_diff_retained", diff, exp[7:0]);
  endtask

  initial begin
    logic [8:0] exp;
    inValid = 0; outReady = 0; bIn = 0; a = 0; b = 0;
    inValid2 = 0; outReady2 = 0; bIn2 = 0; a2 = 0; b2 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", outValid, 0);
    check("rst_in_ready", inReady, 1);
    check("rst_busy", busy, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", bOut, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed cases
    runOp8(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    runOp8(8'h00, 8'h01, 1'b0, 0, 1'b0);
    runOp8(8'hFF, 8'hFF, 1'b1, 0, 1'b1);
    runOp8(8'h80, 8'h7F, 1'b0, 5, 1'b0);

    // Reset in the middle of RUN after two digits
    a = 8'hC3; b = 8'h12; bIn = 1'b1; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", outValid, 0);
    check("abort_in_ready", inReady, 1);
    check("abort_busy", busy, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", bOut, 0);
    repeat (3) begin
      tick();
      check("abort_no_valid", outValid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    runOp8(8'hC3, 8'h12, 1'b1, 1, 1'b0);

    // Random operations
    for (int i = 0; i < 24; i++)
      runOp8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));

    // Exhaustive 2-bit: DIGIT=2 must answer after 1 edge, DIGIT=1 after 2
    outReady2 = 1'b1;
    for (int av = 0; av < 4; av++)
      for (int bv = 0; bv < 4; bv++)
        for (int bi = 0; bi < 2; bi++) begin
          exp = refSub(2, av, bv, bi);
          a2 = 2'(av); b2 = 2'(bv); bIn2 = 1'(bi); inValid2 = 1'b1;
          tick();
          inValid2 = 1'b0;
          a2 = 2'($urandom); b2 = 2'($urandom); bIn2 = 1'($urandom);
          tick();
          check("w2d2_valid", outValid22, 1);
          check("w2d2_diff", diff22, 32'(exp[1:0]));
          check("w2d2_borrow", bOut22, exp[8]);
          check("w2d1_not_yet", outValid21, 0);
          tick();
          check("w2d1_valid", outValid21, 1);
          check("w2d1_diff", diff21, 32'(exp[1:0]));
          check("w2d1_borrow", bOut21, exp[8]);
          tick();
          check("w2_idle", inReady21 & inReady22, 1);
        end
    outReady2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
